serial_subtractor_4bit: RTL and testbench

Bit-serial inverse of the 4-bit ripple adder: given a 5-bit sum and one 4-bit addend, it recovers the other addend one bit per clock. It uses a single full-subtractor cell and a borrow flip-flop. It sits downstream of the adder datapath as a checker/decoder, with a start/done handshake. Each operation takes a fixed 5 processing cycles, and the block flags results that cannot have come from a 4-bit + 4-bit addition.

---
 rtl/serial_subtractor_4bit.sv | 88 ++++++++
 tb/tb_serial_subtractor_4bit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial 5-bit subtractor: recovers num2 = sum - num1 one bit per clock through a single
// full-subtractor cell, flagging differences that no 4-bit + 4-bit addition could produce.
module serial_subtractor_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] sum,
  input  logic [3:0] num1,
  output logic       busy,
  output logic       done,
  output logic [3:0] num2,
  output logic       err
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e     state_q;
  logic [4:0] a_q;
  logic [4:0] b_q;
  logic [4:0] d_q;
  logic       borrow_q;
  logic [2:0] cnt_q;

  logic       diff_bit;
  logic       borrow_d;
  logic [4:0] d_d;

  // Full-subtractor cell on the current LSBs; result enters the top of the shift register.
  always_comb begin
    diff_bit = a_q[0] ^ b_q[0] ^ borrow_q;
    borrow_d = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);
    d_d      = {diff_bit, d_q[4:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      num2     <= '0;
      err      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            state_q  <= StRun;
            a_q      <= sum;
            b_q      <= {1'b0, num1};
            d_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy     <= 1'b1;
          end else begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        StRun: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          d_q      <= d_d;
          borrow_q <= borrow_d;
          cnt_q    <= cnt_q + 3'd1;
          if (cnt_q == 3'd4) begin
            // Final borrow means negative; bit 4 set means the result exceeds 15.
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
            num2    <= d_d[3:0];
            err     <= borrow_d | d_d[4];
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Scoreboard bench for serial_subtractor_4bit: the driver queues hand-computed results and
// the cycle they are due; a negedge monitor pops and checks each done pulse.
module tb_serial_subtractor_4bit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] sum;
  logic [3:0] num1;
  logic       busy;
  logic       done;
  logic [3:0] num2;
  logic       err;

  serial_subtractor_4bit dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sum  (sum),
    .num1 (num1),
    .busy (busy),
    .done (done),
    .num2 (num2),
    .err  (err)
  );

  typedef struct {
    logic [3:0] n2;
    logic       e;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation, on time.
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("num2", int'(num2), int'(e.n2));
        chk("err", int'(err), int'(e.e));
        chk("done_cycle", cyc, e.cyc);
        chk("busy_with_done", int'(busy), 0);
      end
    end
  end

  // Issue one operation; returns at the negedge after E4 so a following call
  // presents its start in DONE (back-to-back).
  task automatic issue(input logic [4:0] s, input logic [3:0] n,
                       input logic [3:0] en2, input logic ee);
    exp_t e;
    @(negedge clk);
    sum   = s;
    num1  = n;
    start = 1'b1;
    e.n2  = en2;
    e.e   = ee;
    e.cyc = cyc + 6;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_e0", int'(busy), 1);
    repeat (4) begin
      @(negedge clk);
      chk("busy_run", int'(busy), 1);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sum   = '0;
    num1  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_num2", int'(num2), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;

    // Basic op, then outputs must hold after the done pulse.
    issue(5'd19, 4'd4, 4'd15, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("hold_done", int'(done), 0);
    chk("hold_num2", int'(num2), 15);
    chk("hold_err", int'(err), 0);
    chk("hold_busy", int'(busy), 0);

    issue(5'd3, 4'd5, 4'b1110, 1'b1);
    issue(5'd31, 4'd0, 4'd15, 1'b1);
    issue(5'd0, 4'd0, 4'd0, 1'b0);

    // Round trip, back-to-back.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [4:0] s;
        s = 5'(a + b);
        issue(s, 4'(a), 4'(b), 1'b0);
      end
    end
    repeat (3) @(negedge clk);

    // Starts during RUN (sampled at E2 and E4) must be ignored.
    begin
      exp_t e;
      @(negedge clk);
      sum   = 5'd10;
      num1  = 4'd3;
      start = 1'b1;
      e.n2  = 4'd7;
      e.e   = 1'b0;
      e.cyc = cyc + 6;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      sum   = 5'd0;
      num1  = 4'd15;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("ignored_start_idle", int'(busy), 0);
    end

    // Reset at E3 aborts the run; no done may follow.
    @(negedge clk);
    sum   = 5'd9;
    num1  = 4'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_num2", int'(num2), 0);
    chk("abort_err", int'(err), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    issue(5'd9, 4'd2, 4'd7, 1'b0);
    repeat (3) @(negedge clk);

    // Reset wins over start on the same edge.
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("rst_start_busy", int'(busy), 0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_start_idle", int'(busy), 0);

    // Drain, bounded.
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    repeat (8) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
